// File: rtl/imem_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and imem.
interface imem_if;
  logic        req;    // request valid; addr held stable while high
  logic [31:0] addr;   // word address, bits[1:0] always zero
  logic        ack;    // one-cycle pulse, rdata valid in that cycle
  logic [31:0] rdata;  // instruction word

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: holds PC_F, talks to a variable-latency instruction memory and
// owns the F/D pipeline register. Wrong-path requests that cannot be cancelled
// are tracked in DROP; data acked while the pipe is stalled is parked in HOLD.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_enab,
  input  logic        enab_FD,
  input  logic        redirect_D,
  input  logic [31:0] redirect_pc_D,
  imem_if.master      imem,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  logic        adv_s;
  logic        redir_s;
  logic [31:0] target_s;
  logic [31:0] pc_next_s;
  logic        deliver_s;
  logic        bubble_s;
  logic [31:0] deliver_word_s;

  assign adv_s     = pc_enab & enab_FD;
  // A redirect is only honoured when the pipe advances; otherwise decode re-evaluates.
  assign redir_s   = redirect_D & adv_s;
  assign target_s  = {redirect_pc_D[31:2], 2'b00};
  assign pc_next_s = pc_f_q + 32'd4;

  // Next-state logic: FSM transitions, PC/buffer updates and F/D load selection.
  always_comb begin
    state_d        = state_q;
    pc_f_d         = pc_f_q;
    drop_addr_d    = drop_addr_q;
    buf_d          = buf_q;
    deliver_s      = 1'b0;
    bubble_s       = 1'b0;
    deliver_word_s = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        state_d  = WAIT;
        bubble_s = adv_s;
      end
      WAIT: begin
        if (redir_s && imem.ack) begin
          pc_f_d   = target_s;
          bubble_s = 1'b1;
        end else if (redir_s) begin
          drop_addr_d = pc_f_q;
          pc_f_d      = target_s;
          bubble_s    = 1'b1;
          state_d     = DROP;
        end else if (imem.ack && adv_s) begin
          deliver_s      = 1'b1;
          deliver_word_s = imem.rdata;
        end else if (imem.ack) begin
          buf_d   = imem.rdata;
          state_d = HOLD;
        end else begin
          bubble_s = adv_s;
        end
      end
      HOLD: begin
        if (redir_s) begin
          pc_f_d   = target_s;
          bubble_s = 1'b1;
          state_d  = WAIT;
        end else if (adv_s) begin
          deliver_s      = 1'b1;
          deliver_word_s = buf_q;
          state_d        = WAIT;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        // The wrong-path request must complete; its data is thrown away.
        if (redir_s) begin
          pc_f_d = target_s;
        end else begin
          pc_f_d = pc_f_q;
        end
        if (imem.ack) begin
          state_d = WAIT;
        end else begin
          state_d = DROP;
        end
        bubble_s = adv_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (deliver_s) begin
      pc_f_d = pc_next_s;
    end else begin
      pc_f_d = pc_f_d;
    end
  end

  // F/D register next value: deliver, bubble, or hold; bubble counter saturates.
  always_comb begin
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (deliver_s) begin
      instr_d    = deliver_word_s;
      pc_plus4_d = pc_next_s;
      valid_d    = 1'b1;
    end else if (bubble_s) begin
      instr_d = 32'h0000_0000;
      valid_d = 1'b0;
      if (bubble_cnt_q != 32'hFFFF_FFFF) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end else begin
      instr_d = instr_q;
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_f_q       <= RESET_PC;
      drop_addr_q  <= 32'h0000_0000;
      buf_q        <= 32'h0000_0000;
      instr_q      <= 32'h0000_0000;
      pc_plus4_q   <= 32'h0000_0000;
      valid_q      <= 1'b0;
      bubble_cnt_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      drop_addr_q  <= drop_addr_d;
      buf_q        <= buf_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign imem.req   = (state_q == WAIT) || (state_q == DROP);
  assign imem.addr  = (state_q == DROP) ? drop_addr_q : pc_f_q;
  assign instr_D    = instr_q;
  assign pc_plus4_D = pc_plus4_q;
  assign valid_D    = valid_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
